// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready/last producers.
// Grants are held for up to MAX_BURST beats; beats and backpressure pass through combinationally.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t        state, state_next;
    logic [GW-1:0] owner, owner_next;
    logic [GW-1:0] last_grant, last_grant_next;
    logic [BW-1:0] beat_cnt, beat_cnt_next;
    logic [GW-1:0] winner;
    logic          owner_valid;
    logic          owner_last;
    logic          xfer;

    assign owner_valid = req_valid[owner];
    assign owner_last  = req_last[owner];
    assign xfer        = (state == BURST) && owner_valid && !fifo_full;

    // Scan starts one past the previous winner so every requester gets a turn.
    always_comb begin
        int unsigned idx;
        logic        found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_grant <= last_grant_next;
            beat_cnt   <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_grant_next = last_grant;
        beat_cnt_next   = beat_cnt;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    owner_next      = winner;
                    last_grant_next = winner;
                    beat_cnt_next   = '0;
                    state_next      = BURST;
                end
            end
            BURST: begin
                if (!owner_valid) begin
                    state_next    = IDLE;
                    beat_cnt_next = '0;
                end else if (xfer) begin
                    if (owner_last || (beat_cnt == BW'(MAX_BURST - 1))) begin
                        state_next    = IDLE;
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt + 1'b1;
                    end
                end
                // Valid but FIFO full: stall with owner and count held.
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == BURST);
        grant_id   = owner;
        fifo_wr_en = xfer;
        fifo_wdata = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
        req_ready  = '0;
        req_ready[owner] = (state == BURST) && !fifo_full;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random bench for fifo_wr_arbiter against a cycle-level grant/burst reference model.
// Handshake: a beat moves when req_valid[i] && req_ready[i]; that cycle must also show fifo_wr_en.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int GW = 2;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             fifo_full;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_wdata;
    logic [GW-1:0]    grant_id;
    logic             busy;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who holds the grant, who won last, beats moved in this grant.
    bit        m_busy;
    int        m_owner;
    int        m_last;
    int        m_beats;
    logic [DW-1:0] exp_q[$];
    int        grant_log[$];
    logic      prev_busy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = NR - 1;
        m_beats = 0;
        exp_q.delete();
        prev_busy = 1'b0;
    endtask

    function automatic logic [NR*DW-1:0] pack(input int slot, input logic [DW-1:0] val);
        logic [NR*DW-1:0] d;
        d = {$urandom, $urandom};
        d[slot*DW +: DW] = val;
        return d;
    endfunction

    // Drive one cycle: set inputs, check outputs mid-cycle, then advance model at posedge.
    task automatic apply(input logic [NR-1:0] v, input logic [NR*DW-1:0] d,
                         input logic [NR-1:0] l, input logic f);
        logic          exp_wr;
        logic [NR-1:0] exp_rdy;
        logic [DW-1:0] got;
        req_valid = v;
        req_data  = d;
        req_last  = l;
        fifo_full = f;
        #2;
        exp_wr  = m_busy && v[m_owner] && !f;
        exp_rdy = (m_busy && !f) ? NR'(1 << m_owner) : '0;
        if (exp_wr) exp_q.push_back(d[m_owner*DW +: DW]);
        chk("busy", 64'(busy), 64'(m_busy));
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("wr_en", 64'(fifo_wr_en), 64'(exp_wr));
        if (m_busy) chk("grant_id", 64'(grant_id), 64'(m_owner));
        if (fifo_wr_en === 1'b1) begin
            if (exp_q.size() == 0) chk("spurious_write", 64'(1), 64'(0));
            else begin
                got = exp_q.pop_front();
                chk("wdata", 64'(fifo_wdata), 64'(got));
            end
        end
        if (busy === 1'b1 && prev_busy !== 1'b1) grant_log.push_back(int'(grant_id));
        prev_busy = busy;
        @(posedge clk);
        #1;
        if (!m_busy) begin
            if (|v) begin
                for (int k = 1; k <= NR; k++) begin
                    if (!m_busy && v[(m_last + k) % NR]) begin
                        m_busy  = 1'b1;
                        m_owner = (m_last + k) % NR;
                    end
                end
                m_last  = m_owner;
                m_beats = 0;
            end
        end else if (!v[m_owner]) begin
            m_busy = 1'b0;
        end else if (!f) begin
            m_beats++;
            if (l[m_owner] || m_beats == MB) m_busy = 1'b0;
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        #2;
        rst_n = 1'b0;
        #3;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_wr_en", 64'(fifo_wr_en), 64'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        model_reset();
        do_reset();

        // Requester 1: three beats A1..A3, last on the third.
        apply(4'b0010, pack(1, 8'hA1), 4'b0000, 1'b0);
        apply(4'b0010, pack(1, 8'hA1), 4'b0000, 1'b0);
        chk("t1_grant_id", 64'(grant_id), 64'(1));
        apply(4'b0010, pack(1, 8'hA2), 4'b0000, 1'b0);
        apply(4'b0010, pack(1, 8'hA3), 4'b0010, 1'b0);
        apply(4'b0000, pack(1, 8'h00), 4'b0000, 1'b0);
        chk("t1_released", 64'(m_busy), 64'(0));

        // All valid, never last: 0,1,2,3,0 with four beats each.
        do_reset();
        grant_log.delete();
        for (int c = 0; c < 22; c++) apply(4'b1111, {$urandom, $urandom}, 4'b0000, 1'b0);
        chk("t2_grants", 64'(grant_log.size()), 64'(5));
        for (int g = 0; g < 5 && g < grant_log.size(); g++)
            chk("t2_grant_seq", 64'(grant_log[g]), 64'(g % NR));

        // Requester 2 stalled by full for two cycles after its second beat.
        do_reset();
        apply(4'b0100, pack(2, 8'h20), 4'b0000, 1'b0);
        apply(4'b0100, pack(2, 8'h21), 4'b0000, 1'b0);
        apply(4'b0100, pack(2, 8'h22), 4'b0000, 1'b0);
        apply(4'b0100, pack(2, 8'h23), 4'b0000, 1'b1);
        apply(4'b0100, pack(2, 8'h23), 4'b0000, 1'b1);
        apply(4'b0100, pack(2, 8'h23), 4'b0000, 1'b0);
        apply(4'b0100, pack(2, 8'h24), 4'b0000, 1'b0);
        chk("t3_released", 64'(busy), 64'(0));

        // Requester 0 drops valid after one beat; requester 3 takes over.
        do_reset();
        apply(4'b1001, pack(0, 8'h01), 4'b0000, 1'b0);
        apply(4'b1001, pack(0, 8'h02), 4'b0000, 1'b0);
        apply(4'b1000, pack(0, 8'h03), 4'b0000, 1'b0);
        apply(4'b1000, pack(3, 8'h30), 4'b0000, 1'b0);
        apply(4'b1000, pack(3, 8'h31), 4'b0000, 1'b0);
        chk("t4_grant_id", 64'(grant_id), 64'(3));

        // Requester 0 last on first beat, then requester 2 granted.
        do_reset();
        apply(4'b0101, pack(0, 8'h0A), 4'b0001, 1'b0);
        apply(4'b0101, pack(0, 8'h0B), 4'b0001, 1'b0);
        apply(4'b0101, pack(2, 8'h2A), 4'b0000, 1'b0);
        apply(4'b0101, pack(2, 8'h2B), 4'b0000, 1'b0);
        chk("t5_grant_id", 64'(grant_id), 64'(2));

        // Reset mid-burst with owner 3 after two beats.
        do_reset();
        apply(4'b1000, pack(3, 8'h3A), 4'b0000, 1'b0);
        apply(4'b1000, pack(3, 8'h3B), 4'b0000, 1'b0);
        apply(4'b1000, pack(3, 8'h3C), 4'b0000, 1'b0);
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #2;
        chk("t6_busy_low", 64'(busy), 64'(0));
        chk("t6_ready_low", 64'(req_ready), 64'(0));
        chk("t6_wr_low", 64'(fifo_wr_en), 64'(0));
        @(posedge clk);
        #2;
        chk("t6_wr_held", 64'(fifo_wr_en), 64'(0));
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("t6_first_winner", 64'(grant_id), 64'(0));
        chk("t6_busy_after", 64'(busy), 64'(1));
        m_busy = 1'b1;
        m_owner = 0;
        m_last = 0;
        m_beats = 0;
        prev_busy = 1'b1;

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            apply(NR'($urandom), {$urandom, $urandom},
                  NR'($urandom_range(0, 3) == 0 ? $urandom : 0),
                  ($urandom_range(0, 3) == 0));
        end
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
